// File: rtl/dpi_pkg.sv
// Shared defaults and helpers for the DFA stream-context block.
package dpi_pkg;

  localparam int unsigned STATE_W_DEF = 11;
  localparam int unsigned SID_W_DEF   = 6;
  localparam int unsigned CNT_W_DEF   = 16;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] satInc(input logic [31:0] value, input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    satInc = (value >= maxVal) ? maxVal : (value + 32'd1);
  endfunction

endpackage

// File: rtl/dfa_stream_ctx_if.sv
// Packet, engine and counter signals of the DFA stream-context block.
interface dfa_stream_ctx_if
  import dpi_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned SID_W   = SID_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
);

  logic               load_state;
  logic [SID_W-1:0]   stream_id;
  logic               new_stream_id;
  logic               enable;
  logic [7:0]         char_in;
  logic               char_in_vld;
  logic               eop;
  logic [7:0]         dfa_char;
  logic               dfa_char_vld;
  logic [STATE_W-1:0] dfa_state_in;
  logic               dfa_state_in_vld;
  logic [STATE_W-1:0] dfa_state_out;
  logic               dfa_accept;
  logic               fired;
  logic [CNT_W-1:0]   total_count;
  logic [SID_W-1:0]   cnt_rd_sid;
  logic [CNT_W-1:0]   cnt_rd_data;
  logic               clr_counts;

  modport master (
    output load_state, stream_id, new_stream_id, enable, char_in, char_in_vld, eop,
           dfa_state_out, dfa_accept, cnt_rd_sid, clr_counts,
    input  dfa_char, dfa_char_vld, dfa_state_in, dfa_state_in_vld, fired,
           total_count, cnt_rd_data
  );

  modport slave (
    input  load_state, stream_id, new_stream_id, enable, char_in, char_in_vld, eop,
           dfa_state_out, dfa_accept, cnt_rd_sid, clr_counts,
    output dfa_char, dfa_char_vld, dfa_state_in, dfa_state_in_vld, fired,
           total_count, cnt_rd_data
  );

endinterface

// File: rtl/dfa_ctx_store.sv
// Per-stream DFA state memory with valid bits and write-to-read forwarding.
// The read happens in the second load stage so that any eop write up to and
// including the same clock edge is reflected in the restored state.
module dfa_ctx_store
  import dpi_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned SID_W   = SID_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [SID_W-1:0]   wr_sid_i,
  input  logic [STATE_W-1:0] wr_state_i,
  input  logic               rd_en_i,
  input  logic               rd_new_i,
  input  logic [SID_W-1:0]   rd_sid_i,
  output logic [STATE_W-1:0] state_in_o,
  output logic               state_in_vld_o
);

  localparam int DEPTH = 1 << SID_W;

  logic [STATE_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [STATE_W-1:0] stateIn_d;
  logic [STATE_W-1:0] stateIn_q;
  logic               stateInVld_q;

  // State storage is not reset; the valid bits make stale entries read as zero.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_i) begin
      mem_q[wr_sid_i] <= wr_state_i;
    end
  end

  // Valid bit per stream, set on the first context write after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_sid_i] <= 1'b1;
    end
  end

  // Choose the state to restore: zero for a new stream, forwarded write data, or memory.
  always_comb begin
    stateIn_d = '0;
    if (!rd_new_i) begin
      if (wr_en_i && (wr_sid_i == rd_sid_i)) begin
        stateIn_d = wr_state_i;
      end else if (valid_q[rd_sid_i]) begin
        stateIn_d = mem_q[rd_sid_i];
      end
    end
  end

  // Register the restored state and its one-cycle load strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateInVld_q <= 1'b0;
    end else begin
      stateInVld_q <= rd_en_i;
    end
    stateIn_q <= stateIn_d;
  end

  assign state_in_o     = stateIn_q;
  assign state_in_vld_o = stateInVld_q;

endmodule

// File: rtl/dfa_stream_ctx.sv
// Multiplexes many packet streams onto one DFA engine: saves/restores the
// engine state per stream and counts matching packets per stream and overall.
module dfa_stream_ctx
  import dpi_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned SID_W   = SID_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  dfa_stream_ctx_if.slave bus
);

  localparam int DEPTH = 1 << SID_W;

  logic [7:0]         dfaChar_q;
  logic               dfaCharVld_q;
  logic [STATE_W-1:0] stateR_q;
  logic               acceptR_q;
  logic               fired_q, fired_d;
  logic               pktActive_q;
  logic               ld1Vld_q;
  logic               ld1New_q;
  logic [SID_W-1:0]   ld1Sid_q;
  logic [CNT_W-1:0]   totalCnt_q, totalCnt_d;
  logic [CNT_W-1:0]   streamCnt_q [DEPTH];
  logic [CNT_W-1:0]   cntRd_q;
  logic               ctxWrEn;
  logic               countInc;

  // An eop only commits when it closes a packet that started after the last reset.
  assign ctxWrEn  = bus.eop && bus.enable && pktActive_q;
  assign countInc = ctxWrEn && fired_q;

  // Valid flags of the byte path and engine feedback pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfaCharVld_q <= 1'b0;
      acceptR_q    <= 1'b0;
      ld1Vld_q     <= 1'b0;
      pktActive_q  <= 1'b0;
    end else begin
      dfaCharVld_q <= bus.char_in_vld;
      acceptR_q    <= bus.dfa_accept;
      ld1Vld_q     <= bus.load_state;
      if (bus.load_state) begin
        pktActive_q <= 1'b1;
      end else if (bus.eop) begin
        pktActive_q <= 1'b0;
      end
    end
  end

  // Data registers of the byte path, engine feedback and first load stage.
  always_ff @(posedge clk) begin
    dfaChar_q <= bus.char_in;
    stateR_q  <= bus.dfa_state_out;
    ld1New_q  <= bus.new_stream_id;
    ld1Sid_q  <= bus.stream_id;
  end

  // Match flag: set by a registered accept, cleared by a new packet or a disabled eop.
  always_comb begin
    fired_d = fired_q;
    if (acceptR_q) begin
      fired_d = 1'b1;
    end else if (bus.load_state || (bus.eop && !bus.enable)) begin
      fired_d = 1'b0;
    end
  end

  // Total match counter; a clear beats a coincident increment.
  always_comb begin
    totalCnt_d = totalCnt_q;
    if (bus.clr_counts) begin
      totalCnt_d = '0;
    end else if (countInc) begin
      totalCnt_d = CNT_W'(satInc(32'(totalCnt_q), CNT_W));
    end
  end

  // Match flag and total counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fired_q    <= 1'b0;
      totalCnt_q <= '0;
    end else begin
      fired_q    <= fired_d;
      totalCnt_q <= totalCnt_d;
    end
  end

  // Per-stream match counters, cleared together by reset or clr_counts.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_counts) begin
      streamCnt_q <= '{default: '0};
    end else if (countInc) begin
      streamCnt_q[bus.stream_id] <= CNT_W'(satInc(32'(streamCnt_q[bus.stream_id]), CNT_W));
    end
  end

  // Registered counter read; sees the value from before any same-edge update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cntRd_q <= '0;
    end else begin
      cntRd_q <= streamCnt_q[bus.cnt_rd_sid];
    end
  end

  dfa_ctx_store #(
    .STATE_W (STATE_W),
    .SID_W   (SID_W)
  ) u_store (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (ctxWrEn),
    .wr_sid_i       (bus.stream_id),
    .wr_state_i     (stateR_q),
    .rd_en_i        (ld1Vld_q),
    .rd_new_i       (ld1New_q),
    .rd_sid_i       (ld1Sid_q),
    .state_in_o     (bus.dfa_state_in),
    .state_in_vld_o (bus.dfa_state_in_vld)
  );

  assign bus.dfa_char     = dfaChar_q;
  assign bus.dfa_char_vld = dfaCharVld_q;
  assign bus.fired        = fired_q;
  assign bus.total_count  = totalCnt_q;
  assign bus.cnt_rd_data  = cntRd_q;

endmodule

// File: tb/tb_dfa_stream_ctx.sv
// Directed testbench for dfa_stream_ctx; the engine is played by the bench
// driving dfa_state_out/dfa_accept directly. Counters are 4 bits wide here.
module tb_dfa_stream_ctx;

  localparam int unsigned STATE_W = 11;
  localparam int unsigned SID_W   = 6;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCnt = 0;
  int   passCnt  = 0;

  dfa_stream_ctx_if #(.STATE_W(STATE_W), .SID_W(SID_W), .CNT_W(CNT_W)) bus ();

  dfa_stream_ctx #(.STATE_W(STATE_W), .SID_W(SID_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic ld, input logic [SID_W-1:0] sid, input logic newId,
                               input logic eopP, input logic en, input logic acc);
    bus.load_state    = ld;
    bus.stream_id     = sid;
    bus.new_stream_id = newId;
    bus.eop           = eopP;
    bus.enable        = en;
    bus.dfa_accept    = acc;
  endtask

  task automatic doLoad(input logic [SID_W-1:0] sid, input logic newId,
                        input logic [STATE_W-1:0] expState, input string tag);
    applyStimulus(1'b1, sid, newId, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, sid, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_vld_t1"}, 32'(bus.dfa_state_in_vld), 32'd0);
    step();
    checkOutput({tag, "_vld_t2"}, 32'(bus.dfa_state_in_vld), 32'd1);
    checkOutput({tag, "_state"}, 32'(bus.dfa_state_in), 32'(expState));
    step();
    checkOutput({tag, "_vld_t3"}, 32'(bus.dfa_state_in_vld), 32'd0);
  endtask

  task automatic doEop(input logic [SID_W-1:0] sid, input logic en);
    applyStimulus(1'b0, sid, 1'b0, 1'b1, en, 1'b0);
    step();
    applyStimulus(1'b0, sid, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runPacket(input logic [SID_W-1:0] sid, input logic clrAtEop);
    applyStimulus(1'b1, sid, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, sid, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b0, sid, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, sid, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, sid, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.clr_counts = clrAtEop;
    step();
    applyStimulus(1'b0, sid, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.clr_counts = 1'b0;
  endtask

  initial begin
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.char_in       = 8'h00;
    bus.char_in_vld   = 1'b0;
    bus.dfa_state_out = '0;
    bus.cnt_rd_sid    = '0;
    bus.clr_counts    = 1'b0;
    rst_n             = 1'b0;
    step(3);
    checkOutput("rst_fired", 32'(bus.fired), 32'd0);
    checkOutput("rst_total", 32'(bus.total_count), 32'd0);
    checkOutput("rst_char_vld", 32'(bus.dfa_char_vld), 32'd0);
    checkOutput("rst_state_in_vld", 32'(bus.dfa_state_in_vld), 32'd0);
    checkOutput("rst_cnt_rd", 32'(bus.cnt_rd_data), 32'd0);
    rst_n = 1'b1;
    step();

    // Byte path: one-cycle delay.
    bus.char_in     = 8'h5A;
    bus.char_in_vld = 1'b1;
    step();
    checkOutput("byte_data", 32'(bus.dfa_char), 32'h5A);
    checkOutput("byte_vld", 32'(bus.dfa_char_vld), 32'd1);
    bus.char_in_vld = 1'b0;
    step();
    checkOutput("byte_vld_off", 32'(bus.dfa_char_vld), 32'd0);

    // New-stream load on sid 5, then a packet ending in 0x111.
    doLoad(6'd5, 1'b1, 11'h000, "new_sid5");
    bus.dfa_state_out = 11'h111;
    step(3);
    doEop(6'd5, 1'b1);
    checkOutput("no_match_total", 32'(bus.total_count), 32'd0);

    // Save 0x2A5 on sid 3 and restore it.
    doLoad(6'd3, 1'b1, 11'h000, "new_sid3");
    bus.dfa_state_out = 11'h2A5;
    step(3);
    doEop(6'd3, 1'b1);
    doLoad(6'd3, 1'b0, 11'h2A5, "restore_sid3");
    doLoad(6'd9, 1'b0, 11'h000, "unwritten_sid9");
    doLoad(6'd5, 1'b0, 11'h111, "restore_sid5");

    // Matching packet on sid 3 with enable=1.
    doLoad(6'd3, 1'b0, 11'h2A5, "ld3_a");
    bus.cnt_rd_sid = 6'd3;
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("fired_lag", 32'(bus.fired), 32'd0);
    step();
    checkOutput("fired_set", 32'(bus.fired), 32'd1);
    step(2);
    doEop(6'd3, 1'b1);
    checkOutput("total_inc", 32'(bus.total_count), 32'd1);
    checkOutput("cnt_prewrite", 32'(bus.cnt_rd_data), 32'd0);
    step();
    checkOutput("cnt_sid3_inc", 32'(bus.cnt_rd_data), 32'd1);

    // Matching packet on sid 3 with enable=0: nothing changes.
    doLoad(6'd3, 1'b0, 11'h2A5, "ld3_b");
    checkOutput("fired_cleared_by_load", 32'(bus.fired), 32'd0);
    bus.dfa_state_out = 11'h0F0;
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fired_set_b", 32'(bus.fired), 32'd1);
    step(2);
    doEop(6'd3, 1'b0);
    checkOutput("fired_en0", 32'(bus.fired), 32'd0);
    checkOutput("total_en0", 32'(bus.total_count), 32'd1);
    step();
    checkOutput("cnt_sid3_en0", 32'(bus.cnt_rd_data), 32'd1);
    doLoad(6'd3, 1'b0, 11'h2A5, "ctx_en0_kept");

    // eop on sid 7 then load one cycle later.
    doLoad(6'd7, 1'b1, 11'h000, "new_sid7");
    bus.dfa_state_out = 11'h3C3;
    step(3);
    doEop(6'd7, 1'b1);
    doLoad(6'd7, 1'b0, 11'h3C3, "hazard_next");

    // eop and load on sid 7 in the same cycle.
    bus.dfa_state_out = 11'h155;
    step(3);
    applyStimulus(1'b1, 6'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("hazard_same_vld", 32'(bus.dfa_state_in_vld), 32'd1);
    checkOutput("hazard_same_state", 32'(bus.dfa_state_in), 32'h155);

    // Load on sid 7 followed by eop the next cycle.
    bus.dfa_state_out = 11'h0AA;
    step(2);
    applyStimulus(1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 6'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hazard_fwd_vld", 32'(bus.dfa_state_in_vld), 32'd1);
    checkOutput("hazard_fwd_state", 32'(bus.dfa_state_in), 32'h0AA);
    step();
    doLoad(6'd7, 1'b0, 11'h0AA, "after_fwd");

    // Sixteen matching packets on sid 10: 4-bit counters saturate at 15.
    for (int i = 0; i < 16; i++) begin
      runPacket(6'd10, 1'b0);
    end
    checkOutput("total_sat", 32'(bus.total_count), 32'd15);
    bus.cnt_rd_sid = 6'd10;
    step();
    checkOutput("cnt_sid10_sat", 32'(bus.cnt_rd_data), 32'd15);
    bus.clr_counts = 1'b1;
    step();
    bus.clr_counts = 1'b0;
    checkOutput("total_clr", 32'(bus.total_count), 32'd0);
    step();
    checkOutput("cnt_sid10_clr", 32'(bus.cnt_rd_data), 32'd0);
    bus.cnt_rd_sid = 6'd3;
    step();
    checkOutput("cnt_sid3_clr", 32'(bus.cnt_rd_data), 32'd0);

    // Clear coincident with a counting eop.
    runPacket(6'd10, 1'b1);
    checkOutput("clr_wins_total", 32'(bus.total_count), 32'd0);
    bus.cnt_rd_sid = 6'd10;
    step();
    checkOutput("clr_wins_cnt", 32'(bus.cnt_rd_data), 32'd0);

    // Count one packet on sid 3, then reset in the middle of a matching packet.
    runPacket(6'd3, 1'b0);
    checkOutput("pre_rst_total", 32'(bus.total_count), 32'd1);
    applyStimulus(1'b1, 6'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 6'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("pre_rst_fired", 32'(bus.fired), 32'd1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    checkOutput("mid_rst_fired", 32'(bus.fired), 32'd0);
    checkOutput("mid_rst_total", 32'(bus.total_count), 32'd0);
    bus.cnt_rd_sid = 6'd3;
    step();
    checkOutput("mid_rst_cnt_sid3", 32'(bus.cnt_rd_data), 32'd0);
    doLoad(6'd3, 1'b0, 11'h000, "post_rst_sid3");
    doLoad(6'd7, 1'b0, 11'h000, "post_rst_sid7");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
